// File: rtl/data_mem_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | data_mem_if: core and loader port bundle for data_mem.                |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
interface data_mem_if #(
    parameter int ADDR_W = 8,
    parameter int WORD_W = 32
);
    logic              mem_read_i;
    logic              mem_write_i;
    logic [ADDR_W-1:0] mem_addr_i;
    logic [WORD_W-1:0] mem_data_i;
    logic [WORD_W-1:0] mem_data_o;
    logic              load_valid_i;
    logic [7:0]        load_byte_i;
    logic              load_last_i;
    logic              load_ready_o;
    logic              busy_o;
    logic              err_o;
`ifdef MEM_STATS_EN
    logic [15:0]       rd_count_o;
    logic [15:0]       wr_count_o;

    modport master (
        output mem_read_i, mem_write_i, mem_addr_i, mem_data_i,
        output load_valid_i, load_byte_i, load_last_i,
        input  mem_data_o, load_ready_o, busy_o, err_o,
        input  rd_count_o, wr_count_o
    );
    modport slave (
        input  mem_read_i, mem_write_i, mem_addr_i, mem_data_i,
        input  load_valid_i, load_byte_i, load_last_i,
        output mem_data_o, load_ready_o, busy_o, err_o,
        output rd_count_o, wr_count_o
    );
`else
    modport master (
        output mem_read_i, mem_write_i, mem_addr_i, mem_data_i,
        output load_valid_i, load_byte_i, load_last_i,
        input  mem_data_o, load_ready_o, busy_o, err_o
    );
    modport slave (
        input  mem_read_i, mem_write_i, mem_addr_i, mem_data_i,
        input  load_valid_i, load_byte_i, load_last_i,
        output mem_data_o, load_ready_o, busy_o, err_o
    );
`endif
endinterface
`default_nettype wire

// File: rtl/data_mem.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | data_mem: byte-organised little-endian data memory with clear/load    |
// | init engine. Optional MEM_STATS_EN adds saturating access counters.   |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
module data_mem #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8,
    parameter int WORD_W = 32
) (
    input  wire        clk,
    input  wire        rst,
    data_mem_if.slave  bus
);
    localparam int              c_BYTES = WORD_W / 8;
    localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_LOAD  = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_clrPtr;
    logic [ADDR_W-1:0] r_loadPtr;
    logic              r_loadReady;
    logic              r_busy;
    logic              r_err;
    logic [7:0]        r_mem [DEPTH];

    logic [ADDR_W-1:0] w_lane   [c_BYTES];
    logic [ADDR_W-1:0] w_wrAddr [c_BYTES];
    logic [7:0]        w_wrData [c_BYTES];
    logic [c_BYTES-1:0] w_wrEn;
    logic [WORD_W-1:0] w_rdWord;
    logic              w_loadAcc;
    logic              w_protoErr;
    logic              w_run;

    assign w_run      = (r_state == S_RUN);
    assign w_loadAcc  = (r_state == S_LOAD) && r_loadReady && bus.load_valid_i;
    assign w_protoErr = w_run ? (bus.mem_read_i && bus.mem_write_i)
                              : (bus.mem_read_i || bus.mem_write_i);

    // Lane addresses wrap naturally because DEPTH == 2**ADDR_W.
    always_comb begin
        w_rdWord = '0;
        for (int k = 0; k < c_BYTES; k++) begin
            w_lane[k]            = bus.mem_addr_i + ADDR_W'(k);
            w_rdWord[8*k +: 8]   = r_mem[w_lane[k]];
        end
    end

    assign bus.mem_data_o = (w_run && bus.mem_read_i) ? w_rdWord : '0;

    always_comb begin
        w_wrEn = '0;
        for (int k = 0; k < c_BYTES; k++) begin
            w_wrAddr[k] = w_lane[k];
            w_wrData[k] = bus.mem_data_i[8*k +: 8];
        end
        case (r_state)
            S_CLEAR: begin
                w_wrEn[0]   = 1'b1;
                w_wrAddr[0] = r_clrPtr;
                w_wrData[0] = 8'h00;
            end
            S_LOAD: begin
                w_wrEn[0]   = w_loadAcc;
                w_wrAddr[0] = r_loadPtr;
                w_wrData[0] = bus.load_byte_i;
            end
            S_RUN: begin
                w_wrEn = {c_BYTES{bus.mem_write_i}};
            end
            default: begin
                w_wrEn = '0;
            end
        endcase
    end

    // Storage has no reset; the CLEAR pass zeroes it after every reset.
    always_ff @(posedge clk) begin
        for (int k = 0; k < c_BYTES; k++) begin
            if (w_wrEn[k]) begin
                r_mem[w_wrAddr[k]] <= w_wrData[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_CLEAR;
            r_clrPtr    <= '0;
            r_loadPtr   <= '0;
            r_loadReady <= 1'b0;
            r_busy      <= 1'b1;
            r_err       <= 1'b0;
        end else begin
            if (w_protoErr) begin
                r_err <= 1'b1;
            end
            case (r_state)
                S_CLEAR: begin
                    r_clrPtr <= r_clrPtr + 1'b1;
                    if (r_clrPtr == c_LAST) begin
                        r_state     <= S_LOAD;
                        r_loadReady <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (w_loadAcc) begin
                        r_loadPtr <= r_loadPtr + 1'b1;
                        if (bus.load_last_i || (r_loadPtr == c_LAST)) begin
                            r_state     <= S_RUN;
                            r_loadReady <= 1'b0;
                            r_busy      <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    r_state <= S_RUN;
                end
                default: begin
                    r_state     <= S_CLEAR;
                    r_clrPtr    <= '0;
                    r_loadReady <= 1'b0;
                    r_busy      <= 1'b1;
                end
            endcase
        end
    end

    assign bus.load_ready_o = r_loadReady;
    assign bus.busy_o       = r_busy;
    assign bus.err_o        = r_err;

`ifdef MEM_STATS_EN
    logic [15:0] r_rdCount;
    logic [15:0] r_wrCount;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdCount <= '0;
            r_wrCount <= '0;
        end else if (w_run) begin
            if (bus.mem_read_i && (r_rdCount != 16'hFFFF)) begin
                r_rdCount <= r_rdCount + 16'd1;
            end
            if (bus.mem_write_i && (r_wrCount != 16'hFFFF)) begin
                r_wrCount <= r_wrCount + 16'd1;
            end
        end
    end

    assign bus.rd_count_o = r_rdCount;
    assign bus.wr_count_o = r_wrCount;
`endif

endmodule
`default_nettype wire

// File: doc/data_mem.md
Name: data_mem

Overview:
Byte-organised data memory that responds to the Y86 core's data-memory port (read/write strobes, 8-bit byte address, 32-bit word).
- Stores words little-endian across four consecutive bytes.
- Reads are combinational. Writes commit on the clock edge.
- After reset, a sequential init engine clears the array and then accepts a serial byte image, before the block starts serving the core.

Parameters:
DEPTH, 256, number of byte locations; power of two, at least 4
ADDR_W, 8, byte address width; log2(DEPTH)
WORD_W, 32, data word width; fixed at 4 bytes

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset
mem_read_i  in  1  core read strobe
mem_write_i  in  1  core write strobe
mem_addr_i  in  ADDR_W  byte address of word's least-significant byte
mem_data_i  in  WORD_W  write data from core
mem_data_o  out  WORD_W  read data to core
load_valid_i  in  1  loader byte valid
load_byte_i  in  8  loader byte
load_last_i  in  1  marks final loader byte
load_ready_o  out  1  block accepts a loader byte this cycle
busy_o  out  1  init in progress; top level holds core in reset while high
err_o  out  1  sticky protocol-error flag

Behaviour:
- Reset (rst low, any time, including mid-clear or mid-load):
  - state enters CLEAR; clear pointer and load pointer go to 0.
  - outputs: mem_data_o=0, load_ready_o=0, busy_o=1, err_o=0.
  - storage array is not reset directly; the CLEAR state zeroes it.
- FSM states: CLEAR, LOAD, RUN.
  - CLEAR: write 0x00 to mem[clr_ptr] each cycle, increment clr_ptr. After writing DEPTH-1, go to LOAD. Takes exactly DEPTH cycles.
  - LOAD: load_ready_o=1. On load_valid_i & load_ready_o, write load_byte_i to mem[load_ptr] and increment load_ptr. Go to RUN when the accepted byte has load_last_i=1, or when the byte at DEPTH-1 is accepted, whichever comes first. If load_valid_i is low, stay in LOAD with no write.
  - RUN: load_ready_o=0, busy_o=0. Terminal state until reset.
- Read in RUN:
  - mem_read_i=1: mem_data_o = {mem[a+3], mem[a+2], mem[a+1], mem[a]}, where a = mem_addr_i and every offset is taken mod DEPTH, so access wraps around the top of the array.
  - mem_read_i=0: mem_data_o=0.
  - Zero-cycle latency.
- Write in RUN:
  - mem_write_i=1: at the rising edge, store mem_data_i[7:0] to a, [15:8] to a+1, [23:16] to a+2, [31:24] to a+3, all mod DEPTH.
  - The new data is visible to a combinational read in the following cycle.
- mem_read_i and mem_write_i both high in RUN:
  - the write is performed;
  - mem_data_o returns the pre-edge (old) contents;
  - err_o is set.
- Core strobe in CLEAR or LOAD: ignored (no write, mem_data_o=0) and err_o is set.
- load_valid_i outside LOAD: ignored, no error.
- err_o stays set until reset.

Optional Feature:
MEM_STATS_EN
- Defined:
  - adds outputs rd_count_o (16) and wr_count_o (16), both 0 on reset.
  - each increments by 1 per RUN cycle with the respective strobe high; both increment in a simultaneous read/write cycle.
  - counters saturate at 0xFFFF and do not wrap.
- Not defined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Release rst, load_valid_i=0 -> busy_o=1 for 256 cycles, then load_ready_o=1. Any mem_read_i in RUN returns 0x00000000 at every address.
- Load bytes 0x10,0x32,0x54,0x76 with last on the 4th byte -> RUN next cycle, busy_o=0. Read addr 0 -> 0x76543210. Read addr 1 -> 0x00765432.
- RUN, write 0xDEADBEEF to addr 0xFE -> next cycle, read 0xFE returns 0xDEADBEEF, read 0x00 returns 0x7654DEAD, read 0xFC returns 0xBEEF0000.
- RUN, read and write both at addr 0x20 with 0x11223344 when it holds 0 -> same cycle mem_data_o=0, next cycle read 0x11223344, err_o=1 and stays 1.
- Assert rst low mid-LOAD after 2 bytes -> outputs return to reset values immediately. Re-init reads all zeros, including the previously loaded bytes.
- With MEM_STATS_EN: 3 reads, 2 writes, 1 simultaneous read/write -> rd_count_o=4, wr_count_o=3. Force rd_count_o to 0xFFFF, then read -> stays 0xFFFF.
